// File: rtl/onehot_pkg.sv
// ============================================================================
//  Module      : onehot_pkg
//  Description : Shared types and constants for the one-hot sequence checker:
//                FSM state enum, default code width, index-width helper and
//                the error-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_pkg;

  // Lock-tracking FSM states
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_BITS = 4;
  localparam int ERR_COUNT_W      = 8;

  // Width of a binary index into an n-bit one-hot code (at least one bit)
  function automatic int index_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_to_bin.sv
// ============================================================================
//  Module      : onehot_to_bin
//  Description : Combinational one-hot to binary decoder. Produces the bit
//                position of the set bit and a flag that is high only when
//                exactly one bit is set. Shared with the display decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_to_bin
  import onehot_pkg::*;
#(
  parameter  int NUM_BITS = DEFAULT_NUM_BITS,
  localparam int IDX_W    = index_width(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0] code,
  output logic [IDX_W-1:0]    index,
  output logic                legal
);

  // OR together the positions of all set bits; exact for legal one-hot input
  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (code[i]) begin
        index = index | IDX_W'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  always_comb begin
    legal = (code != '0) && ((code & (code - NUM_BITS'(1))) == '0);
  end

endmodule

`default_nettype wire

// File: rtl/onehot_sequence_checker.sv
// ============================================================================
//  Module      : onehot_sequence_checker
//  Description : Receive-side checker for a rotate-left one-hot ring-counter
//                stream. Decodes each strobed sample, flags illegal codes and
//                out-of-sequence steps, and tracks lock with a three-state FSM.
//                All outputs are registered (one clock latency).
//  Config      : define ONEHOT_ERR_COUNT_EN to build the saturating error
//                counter; otherwise err_count is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_sequence_checker
  import onehot_pkg::*;
#(
  parameter  int NUM_BITS   = DEFAULT_NUM_BITS,
  parameter  int LOCK_COUNT = 2,
  localparam int IDX_W      = index_width(NUM_BITS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_BITS-1:0]    code_in,
  output logic [IDX_W-1:0]       index,
  output logic                   valid,
  output logic                   locked,
  output logic                   wrap,
  output logic                   err_illegal,
  output logic                   err_seq,
  output logic [ERR_COUNT_W-1:0] err_count
);

  // Run counter holds up to LOCK_COUNT+1 so the increment never overflows
  localparam int RUN_W = $clog2(LOCK_COUNT + 2);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [IDX_W-1:0] index_d, expected_idx, code_idx;
  logic             valid_d, wrap_d, err_illegal_d, err_seq_d;
  logic             code_legal, at_last, in_seq;

  onehot_to_bin #(
    .NUM_BITS (NUM_BITS)
  ) u_decode (
    .code  (code_in),
    .index (code_idx),
    .legal (code_legal)
  );

  // Next expected position follows the rotate-left ring, wrapping MSB -> 0
  always_comb begin
    at_last      = (index == IDX_W'(NUM_BITS - 1));
    expected_idx = at_last ? '0 : index + IDX_W'(1);
    in_seq       = (code_idx == expected_idx);
    run_inc      = (run_q >= RUN_W'(LOCK_COUNT)) ? run_q : run_q + RUN_W'(1);
  end

  // Next-state and next-output decode; everything holds when en is low
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    index_d       = index;
    valid_d       = valid;
    wrap_d        = 1'b0;
    err_illegal_d = 1'b0;
    err_seq_d     = 1'b0;
    if (en) begin
      if (!code_legal) begin
        err_illegal_d = 1'b1;
        valid_d       = 1'b0;
        state_d       = HUNT;
        run_d         = '0;
      end else begin
        valid_d = 1'b1;
        index_d = code_idx;
        unique case (state_q)
          HUNT: begin
            run_d   = RUN_W'(1);
            state_d = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
          end
          ACQUIRE, LOCKED: begin
            if (in_seq) begin
              wrap_d = at_last;
              run_d  = run_inc;
              if (run_inc >= RUN_W'(LOCK_COUNT)) begin
                state_d = LOCKED;
              end
            end else begin
              err_seq_d = 1'b1;
              run_d     = RUN_W'(1);
              state_d   = ACQUIRE;
            end
          end
          default: begin
            state_d = HUNT;
            run_d   = '0;
          end
        endcase
      end
    end
  end

  // State, run counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HUNT;
      run_q       <= '0;
      index       <= '0;
      valid       <= 1'b0;
      wrap        <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      index       <= index_d;
      valid       <= valid_d;
      wrap        <= wrap_d;
      err_illegal <= err_illegal_d;
      err_seq     <= err_seq_d;
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef ONEHOT_ERR_COUNT_EN
  logic [ERR_COUNT_W-1:0] err_cnt_q;

  // Count cycles with an error pulse, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if ((err_illegal || err_seq) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_COUNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

`default_nettype wire
